hex_scan_driver: RTL and testbench

Parametrised multiplexed hex display driver, the successor to the per-segment combinational decoders.
- Decodes all seven segments for every hex nibble 0-F.
- Time-multiplexes NUM_DIGITS digits over one shared segment bus.
- Accepts new display words through a valid/ready handshake and commits them only at frame boundaries, so a frame never shows mixed old and new digits.
- Sits between the datapath and the board-level display pins.

---
 rtl/seg7_pkg.sv | 14 +
 rtl/hex_scan_driver_if.sv | 20 ++
 rtl/hex_to_seg7.sv | 11 +
 rtl/hex_scan_driver.sv | 137 +++++++++++++
 tb/tb_hex_scan_driver.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment display path: bus widths and the
// active-high hex-to-segment table, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int SEG_W   = 7;
  localparam int DIGIT_W = 4;

  // Entry n is the active-high segment pattern for hex digit n.
  localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/hex_scan_driver_if.sv
// Load port of the hex scan driver: a display word plus per-digit blanking,
// moved from the datapath into the driver's shadow registers.
interface hex_scan_driver_if
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  // Handshake: a word transfers on a rising clk edge where load_valid and
  // load_ready are both high. load_ready never depends on load_valid. The
  // source keeps load_data/load_blank stable only up to that edge.
  logic                          load_valid;
  logic                          load_ready;
  logic [DIGIT_W*NUM_DIGITS-1:0] load_data;
  logic [NUM_DIGITS-1:0]         load_blank;

  modport master (output load_valid, load_data, load_blank, input load_ready);
  modport slave  (input load_valid, load_data, load_blank, output load_ready);

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble to seven-segment decoder, active-high outputs.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] nibble_i,
  output logic [SEG_W-1:0]   seg_o
);

  assign seg_o = SEG_TABLE[nibble_i];

endmodule

// File: rtl/hex_scan_driver.sv
// Multiplexed hex display driver. Scans NUM_DIGITS digits over one segment
// bus, SCAN_DIV cycles per digit slot with the first cycle of every slot dark.
// New words land in a shadow register and are committed only at frame
// boundaries (or immediately while the scan is disabled).
module hex_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  hex_scan_driver_if.slave      load_if,
  output logic [SEG_W-1:0]      seg,
  output logic [NUM_DIGITS-1:0] dig_sel,
  output logic                  frame_done
);

  localparam int DATA_W  = DIGIT_W * NUM_DIGITS;
  localparam int PRESC_W = $clog2(SCAN_DIV);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRESC_W-1:0]    PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
  // Output levels for "nothing lit" at the configured polarities.
  localparam logic [SEG_W-1:0]      SEG_OFF   = SEG_ACTIVE_LOW ? {SEG_W{1'b1}} : {SEG_W{1'b0}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF   = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_W-1:0]     disp_data_q, disp_data_d;
  logic [NUM_DIGITS-1:0] disp_blank_q, disp_blank_d;
  logic [DATA_W-1:0]     shadow_data_q, shadow_data_d;
  logic [NUM_DIGITS-1:0] shadow_blank_q, shadow_blank_d;
  logic                  pending_q, pending_d;
  logic [SEG_W-1:0]      seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                  fd_q, fd_d;

  logic                  slot_wrap;
  logic                  frame_wrap;
  logic [DIGIT_W-1:0]    nibble;
  logic [SEG_W-1:0]      dec_seg;
  logic [NUM_DIGITS-1:0] dig_onehot;
  logic                  lit;

  assign slot_wrap  = en && (presc_q == PRESC_MAX);
  assign frame_wrap = slot_wrap && (idx_q == IDX_MAX);

  // Outputs are computed from next-state values so the registered bus lines
  // up with the prescaler: prescaler 0 is always the dark cycle.
  assign nibble     = disp_data_d[idx_d*DIGIT_W +: DIGIT_W];
  assign dig_onehot = NUM_DIGITS'(1) << idx_d;

  hex_to_seg7 u_dec (
    .nibble_i (nibble),
    .seg_o    (dec_seg)
  );

  // Scan counters, shadow load and frame-boundary commit.
  always_comb begin
    presc_d        = presc_q;
    idx_d          = idx_q;
    disp_data_d    = disp_data_q;
    disp_blank_d   = disp_blank_q;
    shadow_data_d  = shadow_data_q;
    shadow_blank_d = shadow_blank_q;
    pending_d      = pending_q;

    if (en) begin
      if (slot_wrap) begin
        presc_d = '0;
        idx_d   = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    // A word that arrives on a boundary edge waits a full frame: only a word
    // already pending at the edge is committed.
    if (pending_q && (frame_wrap || !en)) begin
      disp_data_d  = shadow_data_q;
      disp_blank_d = shadow_blank_q;
      pending_d    = 1'b0;
    end

    if (load_if.load_valid && !pending_q) begin
      shadow_data_d  = load_if.load_data;
      shadow_blank_d = load_if.load_blank;
      pending_d      = 1'b1;
    end
  end

  // Next segment/digit outputs with dead time, blanking and polarity.
  always_comb begin
    lit   = en && (presc_d != '0) && !disp_blank_d[idx_d];
    seg_d = lit ? (dec_seg ^ SEG_OFF) : SEG_OFF;
    dig_d = lit ? (dig_onehot ^ DIG_OFF) : DIG_OFF;
    fd_d  = frame_wrap;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q        <= '0;
      idx_q          <= '0;
      disp_data_q    <= '0;
      disp_blank_q   <= '1;
      shadow_data_q  <= '0;
      shadow_blank_q <= '1;
      pending_q      <= 1'b0;
      seg_q          <= SEG_OFF;
      dig_q          <= DIG_OFF;
      fd_q           <= 1'b0;
    end else begin
      presc_q        <= presc_d;
      idx_q          <= idx_d;
      disp_data_q    <= disp_data_d;
      disp_blank_q   <= disp_blank_d;
      shadow_data_q  <= shadow_data_d;
      shadow_blank_q <= shadow_blank_d;
      pending_q      <= pending_d;
      seg_q          <= seg_d;
      dig_q          <= dig_d;
      fd_q           <= fd_d;
    end
  end

  assign load_if.load_ready = !pending_q;
  assign seg                = seg_q;
  assign dig_sel            = dig_q;
  assign frame_done         = fd_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Bench for hex_scan_driver: two instances (active-high and active-low
// segments) share stimulus and are checked every cycle against a frame
// position model, plus literal checks at chosen slots.
module tb_hex_scan_driver;

  localparam int N     = 4;
  localparam int S     = 4;
  localparam int FRAME = N * S;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         v;
  logic [15:0]  d;
  logic [3:0]   b;
  logic [6:0]   seg_a, seg_b;
  logic [N-1:0] dig_a, dig_b;
  logic         fd_a, fd_b;

  int n_vec = 0;
  int n_mis = 0;

  hex_scan_driver_if #(.NUM_DIGITS(N)) if_a ();
  hex_scan_driver_if #(.NUM_DIGITS(N)) if_b ();

  assign if_a.load_valid = v;
  assign if_a.load_data  = d;
  assign if_a.load_blank = b;
  assign if_b.load_valid = v;
  assign if_b.load_data  = d;
  assign if_b.load_blank = b;

  hex_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .load_if(if_a.slave),
    .seg(seg_a), .dig_sel(dig_a), .frame_done(fd_a)
  );

  hex_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .load_if(if_b.slave),
    .seg(seg_b), .dig_sel(dig_b), .frame_done(fd_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  int         pos;       // position within the frame, 0..FRAME-1
  logic [15:0] m_data, m_sdata;
  logic [3:0]  m_blank, m_sblank;
  logic        m_pending;
  logic [6:0]  m_seg;    // expected active-high segments
  logic [3:0]  m_dig;
  logic        m_fd;

  task automatic model_reset();
    pos       = 0;
    m_data    = 16'h0;
    m_sdata   = 16'h0;
    m_blank   = 4'hF;
    m_sblank  = 4'hF;
    m_pending = 1'b0;
    m_seg     = 7'h00;
    m_dig     = 4'hF;
    m_fd      = 1'b0;
  endtask

  task automatic model_step();
    int k;
    logic at_end;
    logic lit_m;
    logic [3:0] nib;
    at_end = (pos == FRAME - 1);
    m_fd   = en && at_end;
    if (m_pending && (!en || at_end)) begin
      m_data    = m_sdata;
      m_blank   = m_sblank;
      m_pending = 1'b0;
    end else if (v && !m_pending) begin
      m_sdata   = d;
      m_sblank  = b;
      m_pending = 1'b1;
    end
    if (en) pos = (pos + 1) % FRAME;
    k     = pos / S;
    nib   = 4'((m_data >> (4 * k)) & 16'hF);
    lit_m = en && (pos % S != 0) && !m_blank[k];
    m_seg = lit_m ? tbl[nib] : 7'h00;
    m_dig = lit_m ? ~(4'b0001 << k) : 4'hF;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // Every-cycle compare against the model, away from the active edge.
  initial begin
    logic [6:0] seg_inv;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        seg_inv = ~m_seg;
        chk("seg_hi",  {25'd0, seg_a}, {25'd0, m_seg});
        chk("seg_lo",  {25'd0, seg_b}, {25'd0, seg_inv});
        chk("dig_a",   {28'd0, dig_a}, {28'd0, m_dig});
        chk("dig_b",   {28'd0, dig_b}, {28'd0, m_dig});
        chk("fdone_a", {31'd0, fd_a},  {31'd0, m_fd});
        chk("fdone_b", {31'd0, fd_b},  {31'd0, m_fd});
        chk("ready_a", {31'd0, if_a.load_ready}, {31'd0, !m_pending});
        chk("ready_b", {31'd0, if_b.load_ready}, {31'd0, !m_pending});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic skip(input int n);
    repeat (n) tick();
  endtask

  task automatic load(input logic [15:0] data, input logic [3:0] blank);
    bit ok;
    ok = 1'b0;
    v  = 1'b1;
    d  = data;
    b  = blank;
    for (int i = 0; i < 100; i++) begin
      if (if_a.load_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    v = 1'b0;
    d = 16'($urandom);
    b = 4'($urandom);
    n_vec++;
    if (!ok) begin
      n_mis++;
      $display("FAIL load_accept: word %0h not accepted within 100 cycles", data);
    end
  endtask

  task automatic wait_frame();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fd_a) begin
        seen = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!seen) begin
      n_mis++;
      $display("FAIL frame_wait: no frame_done within 100 cycles");
    end
  endtask

  task automatic chk_out(input string name, input logic [6:0] s, input logic [3:0] dg);
    chk({name, "_seg"}, {25'd0, seg_a}, {25'd0, s});
    chk({name, "_dig"}, {28'd0, dig_a}, {28'd0, dg});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    v     = 1'b0;
    d     = 16'h0;
    b     = 4'h0;

    // Reset values.
    #12;
    chk_out("reset", 7'h00, 4'hF);
    chk("reset_seg_lo", {25'd0, seg_b}, 32'h7F);
    chk("reset_ready", {31'd0, if_a.load_ready}, 32'd1);
    chk("reset_fdone", {31'd0, fd_a}, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    en = 1'b1;
    skip(40);

    // Load 0x1234 and watch it through the following frame.
    wait_frame();
    skip(2);
    load(16'h1234, 4'h0);
    chk("ready_after_xfer", {31'd0, if_a.load_ready}, 32'd0);
    wait_frame();
    chk("ready_after_commit", {31'd0, if_a.load_ready}, 32'd1);
    chk_out("s0_dead", 7'h00, 4'hF);
    tick();
    chk_out("s0", 7'h66, 4'b1110);
    chk("model_s0", {25'd0, m_seg}, 32'h66);
    skip(3);
    chk_out("s1_dead", 7'h00, 4'hF);
    tick();
    chk_out("s1", 7'h4F, 4'b1101);
    skip(4);
    chk_out("s2", 7'h5B, 4'b1011);
    skip(4);
    chk_out("s3", 7'h06, 4'b0111);
    chk("model_s3", {28'd0, m_dig}, 32'h7);

    // Second load while the first is still pending.
    load(16'h5678, 4'h0);
    load(16'h9ABC, 4'h0);
    chk_out("first_word", 7'h7F, 4'b1110);
    wait_frame();
    tick();
    chk_out("second_word", 7'h39, 4'b1110);

    // All F with digit 2 blanked, both segment polarities.
    load(16'hFFFF, 4'b0100);
    wait_frame();
    tick();
    chk_out("ffff_s0", 7'h71, 4'b1110);
    chk("ffff_s0_lo", {25'd0, seg_b}, 32'h0E);
    skip(8);
    chk_out("ffff_s2_blank", 7'h00, 4'hF);
    chk("ffff_s2_lo", {25'd0, seg_b}, 32'h7F);

    // Drop en mid-slot 2 with a word pending.
    load(16'h5A3C, 4'h0);
    en = 1'b0;
    tick();
    chk_out("en_off", 7'h00, 4'hF);
    chk("en_off_commit", {31'd0, if_a.load_ready}, 32'd1);
    chk("en_off_fdone", {31'd0, fd_a}, 32'd0);
    skip(2);
    en = 1'b1;
    chk_out("reenable_dark", 7'h00, 4'hF);
    tick();
    chk_out("resume_s2", 7'h77, 4'b1011);

    // Asynchronous reset mid-frame.
    skip(3);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 7'h00, 4'hF);
    chk("async_rst_lo", {25'd0, seg_b}, 32'h7F);
    chk("async_rst_ready", {31'd0, if_a.load_ready}, 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    skip(40);

    // Random traffic with occasional scan-enable toggles.
    for (int i = 0; i < 500; i++) begin
      v = ($urandom_range(0, 2) == 0);
      d = 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 24) == 0) en = ~en;
      tick();
    end
    v  = 1'b0;
    en = 1'b1;
    skip(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
